// File: rtl/shift_pkg.sv
// Shared constants and helpers for the pipelined barrel shifter.
package shift_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Number of bits needed to express a shift of 0..width-1 (ceil log2).
  function automatic int shw_of(input int width);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < width) n = i + 1;
    end
    return n;
  endfunction

  // Codes above ROR carry no shift and flag the result as an error.
  function automatic logic is_reserved(input logic [2:0] op);
    return (op > OP_ROR);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel level: conditional shift by DIST followed by its pipeline register.
module shift_stage
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DIST  = 1,
  localparam int SHW   = shw_of(WIDTH),
  localparam int BIT   = shw_of(DIST)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ld_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic [2:0]       op_i,
  input  logic             err_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   shamt_o,
  output logic [2:0]       op_o,
  output logic             err_o
);

  logic [WIDTH-1:0] shifted;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d,  data_q;
  logic [SHW-1:0]   shamt_d, shamt_q;
  logic [2:0]       op_d,    op_q;
  logic             err_d,   err_q;

  // Apply this level's fixed distance when its shift-amount bit is set.
  always_comb begin
    shifted = data_i;
    if (shamt_i[BIT]) begin
      case (op_i)
        OP_SLL:  shifted = data_i << DIST;
        OP_SRL:  shifted = data_i >> DIST;
        OP_SRA:  shifted = $signed(data_i) >>> DIST;
        OP_ROL:  shifted = (data_i << DIST) | (data_i >> (WIDTH - DIST));
        OP_ROR:  shifted = (data_i >> DIST) | (data_i << (WIDTH - DIST));
        default: shifted = data_i;
      endcase
    end
  end

  // Capture the upstream payload only when this stage is allowed to load.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    err_d   = err_q;
    if (ld_i) begin
      valid_d = valid_i;
      data_d  = shifted;
      shamt_d = shamt_i;
      op_d    = op_i;
      err_d   = err_i;
    end
  end

  // Stage register; reset empties the stage and clears its payload.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign op_o    = op_q;
  assign err_o   = err_q;

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined log barrel shifter: SHW levels, MSB distance first, with
// valid/ready flow control that collapses bubbles.
module pipe_shifter
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = shw_of(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_err
);

  // Index 0 is the request port; index k+1 is the register of stage k.
  logic [SHW:0]            v_pipe;
  logic [SHW:0][WIDTH-1:0] d_pipe;
  logic [SHW:0][SHW-1:0]   s_pipe;
  logic [SHW:0][2:0]       o_pipe;
  logic [SHW:0]            e_pipe;
  logic [SHW-1:0]          ld;

  assign v_pipe[0] = in_valid;
  assign d_pipe[0] = in_data;
  assign s_pipe[0] = in_shamt;
  assign o_pipe[0] = in_op;
  assign e_pipe[0] = in_valid & is_reserved(in_op);

  // A stage loads when empty or when its successor loads; the tail follows out_ready.
  always_comb begin
    ld = '0;
    ld[SHW-1] = ~v_pipe[SHW] | out_ready;
    for (int k = SHW - 2; k >= 0; k--) begin
      ld[k] = ~v_pipe[k+1] | ld[k+1];
    end
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << (SHW - 1 - k))
    ) u_stage (
      .clock   (clock),
      .reset_n (reset_n),
      .ld_i    (ld[k]),
      .valid_i (v_pipe[k]),
      .data_i  (d_pipe[k]),
      .shamt_i (s_pipe[k]),
      .op_i    (o_pipe[k]),
      .err_i   (e_pipe[k]),
      .valid_o (v_pipe[k+1]),
      .data_o  (d_pipe[k+1]),
      .shamt_o (s_pipe[k+1]),
      .op_o    (o_pipe[k+1]),
      .err_o   (e_pipe[k+1])
    );
  end

  assign in_ready  = ld[0];
  assign out_valid = v_pipe[SHW];
  assign out_data  = d_pipe[SHW];
  assign out_zero  = v_pipe[SHW] & (d_pipe[SHW] == '0);
  assign out_err   = v_pipe[SHW] & e_pipe[SHW];

  // Shift amount and op are fully consumed by the last level.
  logic unused_tail;
  assign unused_tail = ^{s_pipe[SHW], o_pipe[SHW]};

endmodule

// File: tb/tb_pipe_shifter.sv
// Directed bench for pipe_shifter at WIDTH=32.
module tb_pipe_shifter;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_err;

  int tests = 0;
  int fails = 0;

  pipe_shifter #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_err   (out_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated transaction with out_ready=1: checks acceptance, 5-cycle latency, result, drain.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] data,
                        input logic [4:0] sh, input logic [31:0] exp, input logic exp_err);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = data;
    in_shamt = sh;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk({tag, " early"}, 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " data"}, out_data, exp);
    chk({tag, " err"}, 32'(out_err), 32'(exp_err));
    chk({tag, " zero"}, 32'(out_zero), 32'(exp == 32'd0));
    @(posedge clock); #1;
    chk({tag, " drained"}, 32'(out_valid), 32'd0);
  endtask

  logic [2:0]  s_op  [8];
  logic [31:0] s_in  [8];
  logic [4:0]  s_sh  [8];
  logic [31:0] s_exp [8];

  initial begin
    int sent;
    int recv;
    int n;
    int extra;
    logic saw_stall;

    s_op[0] = 3'b000; s_in[0] = 32'h0000_0003; s_sh[0] = 5'd4;  s_exp[0] = 32'h0000_0030;
    s_op[1] = 3'b001; s_in[1] = 32'hF000_0000; s_sh[1] = 5'd8;  s_exp[1] = 32'h00F0_0000;
    s_op[2] = 3'b010; s_in[2] = 32'h8000_0000; s_sh[2] = 5'd4;  s_exp[2] = 32'hF800_0000;
    s_op[3] = 3'b011; s_in[3] = 32'h1234_5678; s_sh[3] = 5'd8;  s_exp[3] = 32'h3456_7812;
    s_op[4] = 3'b100; s_in[4] = 32'h1234_5678; s_sh[4] = 5'd8;  s_exp[4] = 32'h7812_3456;
    s_op[5] = 3'b000; s_in[5] = 32'h0000_FFFF; s_sh[5] = 5'd16; s_exp[5] = 32'hFFFF_0000;
    s_op[6] = 3'b010; s_in[6] = 32'h7FFF_FFFF; s_sh[6] = 5'd31; s_exp[6] = 32'h0000_0000;
    s_op[7] = 3'b100; s_in[7] = 32'h0000_0001; s_sh[7] = 5'd1;  s_exp[7] = 32'h8000_0000;

    reset_n   = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b1;
    #2 reset_n = 1'b0;
    #10;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset out_zero", 32'(out_zero), 32'd0);
    chk("reset out_err", 32'(out_err), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk("post-reset in_ready", 32'(in_ready), 32'd1);

    run_op("sra_neg_31", 3'b010, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0);
    run_op("srl_31",     3'b001, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0);
    run_op("sll_31",     3'b000, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
    run_op("ror_4",      3'b100, 32'h0000_000F, 5'd4,  32'hF000_0000, 1'b0);
    run_op("rol_1",      3'b011, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0);
    run_op("sll_0",      3'b000, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0);
    run_op("op111",      3'b111, 32'h1234_5678, 5'd5,  32'h1234_5678, 1'b1);
    run_op("op101",      3'b101, 32'h0000_0000, 5'd3,  32'h0000_0000, 1'b1);
    run_op("sll_ones_0", 3'b000, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF, 1'b0);
    run_op("srl_to_zero",3'b001, 32'h0000_0001, 5'd1,  32'h0000_0000, 1'b0);
    run_op("rol_16",     3'b011, 32'h1234_5678, 5'd16, 32'h5678_1234, 1'b0);
    run_op("sra_pos_30", 3'b010, 32'h4000_0000, 5'd30, 32'h0000_0001, 1'b0);
    run_op("ror_0",      3'b100, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0);

    // Back-to-back stream with out_ready low in cycles 3..6.
    sent = 0;
    recv = 0;
    saw_stall = 1'b0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_op    = s_op[sent];
        in_data  = s_in[sent];
        in_shamt = s_sh[sent];
      end
      #1;
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (out_valid && !out_ready && recv < 8) chk("stream hold", out_data, s_exp[recv]);
      if (out_valid && out_ready) begin
        if (recv < 8) begin
          chk("stream data", out_data, s_exp[recv]);
          chk("stream zero", 32'(out_zero), 32'(s_exp[recv] == 32'd0));
        end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clock); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream sent", 32'(sent), 32'd8);
    chk("stream recv", 32'(recv), 32'd8);
    chk("stream in_ready stalled", 32'(saw_stall), 32'd1);
    extra = 0;
    repeat (8) begin
      if (out_valid) extra++;
      @(posedge clock); #1;
    end
    chk("stream no duplicates", 32'(extra), 32'd0);

    // Reset with three results in flight, the oldest parked at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_op    = 3'b000;
      in_data  = 32'h0000_0011 << i;
      in_shamt = 5'd1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("inflight out_valid", 32'(out_valid), 32'd1);
    chk("inflight data", out_data, 32'h0000_0022);
    #2 reset_n = 1'b0;
    #1;
    chk("mid reset out_valid", 32'(out_valid), 32'd0);
    chk("mid reset out_data", out_data, 32'd0);
    chk("mid reset out_zero", 32'(out_zero), 32'd0);
    chk("mid reset out_err", 32'(out_err), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    chk("release in_ready", 32'(in_ready), 32'd1);
    extra = 0;
    repeat (10) begin
      if (out_valid) extra++;
      @(posedge clock); #1;
    end
    chk("no stale output", 32'(extra), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
